snow64_bfloat16_vector_cast_from_int: RTL and testbench
=======================================================

Name: snow64_bfloat16_vector_cast_from_int

Overview:
- Sequencer that converts a 256-bit vector of packed integers into a 256-bit vector of packed BFloat16 values, one element at a time.
- Sits between the vector register/LAR data path and the scalar BFloat16 cast-from-int unit. It feeds that unit element by element and packs its results.
- Used by the vector cast instruction path ahead of the BFloat16 vector FPU.

Parameters:
- WIDTH__VEC, 256, vector data width in bits.
- NUM_BF16_LANES, 16, BFloat16 lanes per output vector (WIDTH__VEC/16).

Ports:
- clk  in  1  clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- in_start  in  1  command strobe; sampled only when out_can_accept_cmd=1.
- in_to_cast  in  256  packed source integers; element i occupies bits [i*W+W-1 : i*W].
- in_int_type_size  in  2  PkgSnow64Cpu int type size: 8/16/32/64-bit elements.
- in_type_signedness  in  1  0 = unsigned, 1 = signed source elements.
- out_valid  out  1  1-cycle pulse; out_data is valid in this cycle.
- out_can_accept_cmd  out  1  1 = idle and able to accept in_start.
- out_data  out  256  packed BFloat16 results; lane i is bits [16i+15:16i].

Behaviour:
- Reset (rst=1 at posedge):
  - state <= StIdle; out_valid <= 0; out_can_accept_cmd <= 1; out_data <= 0; lane counter <= 0.
  - Reset mid-operation abandons the command with no out_valid. The scalar unit's in-flight result is ignored.
  - The scalar unit has no reset, so after rst the block waits for the scalar unit's can_accept_cmd=1 before issuing anything.
- Element count N by in_int_type_size: 8-bit -> 16, 16-bit -> 16, 32-bit -> 8, 64-bit -> 4.
- 8-bit sources: only bytes 0..15 (bits 127:0) are converted. Bits 255:128 are ignored.
- Output lanes N..15 are forced to 16'h0000.
- Capture: on in_start with out_can_accept_cmd=1, capture to_cast, type size and signedness; out_can_accept_cmd <= 0; out_valid <= 0; out_data cleared.
- in_start is ignored while out_can_accept_cmd=0.
- States:
  - StIdle: waits for in_start, then -> StIssue with lane counter = 0.
  - StIssue: when the scalar unit's can_accept_cmd=1, drive its start=1 for exactly one cycle with the following, then -> StWait:
    - to_cast = element[lane] zero-extended to 64 bits;
    - int_type_size and type_signedness = captured values.
  - StWait: on the scalar unit's valid=1, write its data into lane[counter] of the result register.
    - If counter == N-1: -> StDone.
    - Otherwise: counter++ and -> StIssue.
    - Ignore the scalar unit's valid while in StIssue; it may be stale-high from the previous element.
  - StDone: out_data <= result; out_valid <= 1 for one cycle; out_can_accept_cmd <= 1; -> StIdle.
- Back-to-back commands:
  - A new in_start is accepted in the cycle out_can_accept_cmd first reads 1.
  - out_data holds its value until the next StDone or reset.
- Latency: with the scalar unit's 2-cycle command-to-valid time, each element costs 3 cycles. Total is 3N+2 cycles from in_start to out_valid: 50 for 8- and 16-bit, 26 for 32-bit, 14 for 64-bit.
- Arithmetic and rounding are owned entirely by the scalar unit. This block never modifies lane values except zero-filling unused lanes.
- Counter is 4 bits; it must never wrap, since N-1 ≤ 15.

Decomposition:
- PkgSnow64BFloat16 additions:
  - PortIn_VecCastFromInt / PortOut_VecCastFromInt packed structs mirroring the ports above.
  - WIDTH__SNOW64_BFLOAT16_VEC_LANES constant (16).
  - State enum StIdle/StIssue/StWait/StDone (2-bit).
  - Localparam table of N per int type size.
- One sub-module: an instance of Snow64BFloat16CastFromInt, driven through its PortIn_CastFromInt/PortOut_CastFromInt structs.
- Lane extraction is an inline case on captured type size; no further sub-modules.

Test Plan:
- Unsigned 8-bit, bytes 0..15 = 8'h01, upper 128 bits = 8'hFF -> every lane = 16'h3F80; out_valid 50 cycles after in_start.
- Signed 16-bit, lane0 = 16'hFFFF (-1), lane1 = 16'h0002, rest 0 -> lane0 = 16'hBF80, lane1 = 16'h4000, others 16'h0000.
- Unsigned 32-bit, all eight elements = 32'd255 -> lanes 0..7 = 16'h437F, lanes 8..15 = 16'h0000; latency 26.
- Signed 64-bit, elements {-1, 1, 0, 2} -> lanes 0..3 = {16'hBF80, 16'h3F80, 16'h0000, 16'h4000}, lanes 4..15 = 0; latency 14.
- Two back-to-back commands, with in_start held high throughout the first -> exactly two out_valid pulses, each carrying correct data; in_start while busy has no effect.
- rst asserted in StWait of lane 5 -> next cycle out_can_accept_cmd = 1, out_valid = 0, out_data = 0; a fresh 64-bit command afterwards completes correctly.

Source files
------------

// File: rtl/snow64_bfloat16_vector_cast_from_int_pkg.sv
// Shared types and constants for the BFloat16 vector cast-from-int sequencer.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package snow64_bfloat16_vector_cast_from_int_pkg;

  localparam int WIDTH__VEC                      = 256;
  localparam int WIDTH__BF16                     = 16;
  localparam int WIDTH__SNOW64_BFLOAT16_VEC_LANES = 16;
  localparam int NUM_BF16_LANES                  = WIDTH__VEC / WIDTH__BF16;

  // Source integer element size, encoded as in the CPU package.
  typedef enum logic [1:0] {
    IntTypSz8  = 2'd0,
    IntTypSz16 = 2'd1,
    IntTypSz32 = 2'd2,
    IntTypSz64 = 2'd3
  } int_typ_sz_t;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StIssue = 2'd1,
    StWait  = 2'd2,
    StDone  = 2'd3
  } state_t;

  // Number of elements converted per command, indexed by int_typ_sz_t.
  // 8-bit sources only use the low 16 bytes since there are 16 output lanes.
  localparam logic [4:0] NUM_ELEMS_TAB [4] = '{5'd16, 5'd16, 5'd8, 5'd4};

  typedef struct packed {
    logic                  start;
    logic [WIDTH__VEC-1:0] to_cast;
    int_typ_sz_t           int_type_size;
    logic                  type_signedness;
  } PortIn_VecCastFromInt;

  typedef struct packed {
    logic                  valid;
    logic                  can_accept_cmd;
    logic [WIDTH__VEC-1:0] data;
  } PortOut_VecCastFromInt;

  typedef struct packed {
    logic        start;
    logic [63:0] to_cast;
    int_typ_sz_t int_type_size;
    logic        type_signedness;
  } PortIn_CastFromInt;

  typedef struct packed {
    logic                   valid;
    logic                   can_accept_cmd;
    logic [WIDTH__BF16-1:0] data;
  } PortOut_CastFromInt;

endpackage

// File: rtl/snow64_bfloat16_vector_cast_from_int_if.sv
// Command/result bundle between the vector data path and the cast sequencer.
// Latency: n/a (wiring only).
// Backpressure: master may only assert in_start while out_can_accept_cmd=1.
interface snow64_bfloat16_vector_cast_from_int_if;
  import snow64_bfloat16_vector_cast_from_int_pkg::*;

  logic                  in_start;
  logic [WIDTH__VEC-1:0] in_to_cast;
  int_typ_sz_t           in_int_type_size;
  logic                  in_type_signedness;
  logic                  out_valid;
  logic                  out_can_accept_cmd;
  logic [WIDTH__VEC-1:0] out_data;

  modport master (
    output in_start, in_to_cast, in_int_type_size, in_type_signedness,
    input  out_valid, out_can_accept_cmd, out_data
  );

  modport slave (
    input  in_start, in_to_cast, in_int_type_size, in_type_signedness,
    output out_valid, out_can_accept_cmd, out_data
  );
endinterface

// File: rtl/snow64_bfloat16_vector_cast_from_int_scalar.sv
// Scalar integer -> BFloat16 converter, round-to-nearest-even.
// Latency: valid pulses 2 cycles after the start cycle.
// Backpressure: can_accept_cmd drops for one cycle after each start; no reset.
module snow64_bfloat16_vector_cast_from_int_scalar
  import snow64_bfloat16_vector_cast_from_int_pkg::*;
(
  input  logic               clk,
  input  PortIn_CastFromInt  in_i,
  output PortOut_CastFromInt out_o
);

  logic        s1_vld_q;
  logic [63:0] s1_to_cast_q;
  int_typ_sz_t s1_size_q;
  logic        s1_signed_q;
  logic        vld_q;
  logic [15:0] data_q;

  function automatic logic [15:0] int_to_bf16(input logic [63:0] raw,
                                              input int_typ_sz_t sz,
                                              input logic sgn);
    logic [63:0] val, mag, norm;
    logic        neg, rnd;
    logic [5:0]  msb;
    logic [8:0]  sig;
    logic [7:0]  expo;
    logic [6:0]  mant;
    case (sz)
      IntTypSz8:  val = {{56{sgn & raw[7]}},  raw[7:0]};
      IntTypSz16: val = {{48{sgn & raw[15]}}, raw[15:0]};
      IntTypSz32: val = {{32{sgn & raw[31]}}, raw[31:0]};
      default:    val = raw;
    endcase
    neg = sgn & val[63];
    // Magnitude of -2^63 still fits as an unsigned 64-bit value.
    mag = neg ? (~val + 64'd1) : val;
    msb = 6'd0;
    for (int i = 0; i < 64; i++) begin
      if (mag[i]) msb = 6'(i);
    end
    // Left-justify so the hidden bit sits at bit 63; guard is bit 55.
    norm = mag << (6'd63 - msb);
    rnd  = norm[55] & ((|norm[54:0]) | norm[56]);
    sig  = {1'b0, norm[63:56]} + {8'd0, rnd};
    expo = 8'd127 + {2'b00, msb} + {7'd0, sig[8]};
    mant = sig[8] ? sig[7:1] : sig[6:0];
    return (mag == 64'd0) ? 16'h0000 : {neg, expo, mant};
  endfunction

  // Stage 1 captures the command, stage 2 converts and presents the result.
  always_ff @(posedge clk) begin
    s1_vld_q <= in_i.start;
    if (in_i.start) begin
      s1_to_cast_q <= in_i.to_cast;
      s1_size_q    <= in_i.int_type_size;
      s1_signed_q  <= in_i.type_signedness;
    end
    vld_q <= s1_vld_q;
    if (s1_vld_q) data_q <= int_to_bf16(s1_to_cast_q, s1_size_q, s1_signed_q);
  end

  assign out_o = '{valid: vld_q, can_accept_cmd: ~s1_vld_q, data: data_q};

endmodule

// File: rtl/snow64_bfloat16_vector_cast_from_int.sv
// Converts a 256-bit vector of packed integers to packed BFloat16, one element at a time.
// Latency: 3N+2 cycles from in_start to out_valid (N = 16/16/8/4 for 8/16/32/64-bit).
// Backpressure: in_start is ignored while out_can_accept_cmd=0; out_valid is a 1-cycle pulse.
module snow64_bfloat16_vector_cast_from_int
  import snow64_bfloat16_vector_cast_from_int_pkg::*;
(
  input logic clk,
  input logic rst,
  snow64_bfloat16_vector_cast_from_int_if.slave bus
);

  PortIn_VecCastFromInt  cmd_i;
  PortOut_VecCastFromInt res_q;
  PortIn_CastFromInt     scalar_in;
  PortOut_CastFromInt    scalar_out;

  state_t                state_q;
  logic [3:0]            lane_q;
  logic [WIDTH__VEC-1:0] to_cast_q;
  int_typ_sz_t           size_q;
  logic                  signed_q;
  logic [WIDTH__VEC-1:0] result_q;
  logic [63:0]           elem;
  logic [4:0]            num_elems;
  logic                  is_last;

  assign cmd_i = '{start:           bus.in_start,
                   to_cast:         bus.in_to_cast,
                   int_type_size:   bus.in_int_type_size,
                   type_signedness: bus.in_type_signedness};

  assign bus.out_valid          = res_q.valid;
  assign bus.out_can_accept_cmd = res_q.can_accept_cmd;
  assign bus.out_data           = res_q.data;

  assign num_elems = NUM_ELEMS_TAB[size_q];
  assign is_last   = ({1'b0, lane_q} == (num_elems - 5'd1));

  // Pick the current element out of the captured vector, zero-extended to 64 bits.
  always_comb begin
    elem = 64'd0;
    case (size_q)
      IntTypSz8:  elem = {56'd0, to_cast_q[{1'b0, lane_q, 3'b000} +: 8]};
      IntTypSz16: elem = {48'd0, to_cast_q[{lane_q, 4'b0000} +: 16]};
      IntTypSz32: elem = {32'd0, to_cast_q[{lane_q[2:0], 5'b00000} +: 32]};
      default:    elem = to_cast_q[{lane_q[1:0], 6'b000000} +: 64];
    endcase
  end

  // Start is held off during reset so nothing new enters the scalar unit.
  assign scalar_in = '{start:           (state_q == StIssue) && scalar_out.can_accept_cmd && !rst,
                       to_cast:         elem,
                       int_type_size:   size_q,
                       type_signedness: signed_q};

  snow64_bfloat16_vector_cast_from_int_scalar u_cast_from_int (
    .clk   (clk),
    .in_i  (scalar_in),
    .out_o (scalar_out)
  );

  // Sequencer: capture, issue each element, collect its lane, publish the vector.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      lane_q    <= 4'd0;
      to_cast_q <= '0;
      size_q    <= IntTypSz8;
      signed_q  <= 1'b0;
      result_q  <= '0;
      res_q     <= '{valid: 1'b0, can_accept_cmd: 1'b1, data: '0};
    end else begin
      res_q.valid <= 1'b0;
      case (state_q)
        StIdle: begin
          if (cmd_i.start && res_q.can_accept_cmd) begin
            to_cast_q            <= cmd_i.to_cast;
            size_q               <= cmd_i.int_type_size;
            signed_q             <= cmd_i.type_signedness;
            result_q             <= '0;
            lane_q               <= 4'd0;
            res_q.can_accept_cmd <= 1'b0;
            state_q              <= StIssue;
          end
        end
        StIssue: begin
          // A valid seen here belongs to the previous element; ignore it.
          if (scalar_out.can_accept_cmd) state_q <= StWait;
        end
        StWait: begin
          if (scalar_out.valid) begin
            result_q[{lane_q, 4'b0000} +: 16] <= scalar_out.data;
            if (is_last) begin
              state_q <= StDone;
            end else begin
              lane_q  <= lane_q + 4'd1;
              state_q <= StIssue;
            end
          end
        end
        default: begin
          res_q.data           <= result_q;
          res_q.valid          <= 1'b1;
          res_q.can_accept_cmd <= 1'b1;
          state_q              <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_snow64_bfloat16_vector_cast_from_int.sv
// Self-checking bench for the BFloat16 vector cast-from-int sequencer.
// Directed cases plus randomized commands against an arithmetic reference model.
// Covers latency, one-cycle out_valid, back-to-back commands and mid-operation reset.
module tb_snow64_bfloat16_vector_cast_from_int;
  import snow64_bfloat16_vector_cast_from_int_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  snow64_bfloat16_vector_cast_from_int_if bus();

  snow64_bfloat16_vector_cast_from_int dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Integer magnitude -> BFloat16 by explicit division and round-half-even.
  function automatic logic [15:0] ref_bf16(input logic [63:0] e, input int w, input bit sg);
    logic [63:0] mag, q, rem, unit;
    bit neg;
    int p, ex;
    neg = sg && e[w-1];
    if (neg) mag = (w == 64) ? (~e + 64'd1) : ((64'd1 << w) - e);
    else     mag = e;
    if (mag == 64'd0) return 16'h0000;
    p = 63;
    while (!mag[p]) p--;
    ex = 127 + p;
    if (p <= 7) begin
      q = mag << (7 - p);
    end else begin
      unit = 64'd1 << (p - 7);
      q    = mag / unit;
      rem  = mag % unit;
      if ((rem * 2 > unit) || ((rem * 2 == unit) && q[0])) q = q + 64'd1;
      if (q == 64'd256) begin
        q  = 64'd128;
        ex = ex + 1;
      end
    end
    return {neg, 8'(ex), q[6:0]};
  endfunction

  function automatic int num_elems(input logic [1:0] sz);
    return (sz == 2'd0) ? 16 : 256 / (8 << sz);
  endfunction

  function automatic logic [255:0] ref_vec(input logic [255:0] v, input logic [1:0] sz, input bit sg);
    logic [255:0] r, tmp;
    logic [63:0]  e;
    int w;
    w = 8 << sz;
    r = '0;
    for (int i = 0; i < num_elems(sz); i++) begin
      tmp = v >> (i * w);
      e   = tmp[63:0];
      if (w < 64) e = e & ((64'd1 << w) - 64'd1);
      r[i*16 +: 16] = ref_bf16(e, w, sg);
    end
    return r;
  endfunction

  function automatic logic [255:0] rand_vec();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  // Issue one command and wait (bounded) for its result; lat = -1 on timeout.
  task automatic run_cmd(input logic [255:0] v, input logic [1:0] sz, input logic sg,
                         output logic [255:0] got, output int lat,
                         output logic after_vld, output logic [255:0] after_dat);
    bus.in_to_cast         = v;
    bus.in_int_type_size   = int_typ_sz_t'(sz);
    bus.in_type_signedness = sg;
    bus.in_start           = 1'b1;
    @(posedge clk); #1;
    bus.in_start = 1'b0;
    lat       = -1;
    got       = '0;
    after_vld = 1'b1;
    after_dat = '0;
    for (int k = 2; k <= 200; k++) begin
      @(posedge clk); #1;
      if (bus.out_valid === 1'b1) begin
        lat = k;
        got = bus.out_data;
        break;
      end
    end
    if (lat > 0) begin
      @(posedge clk); #1;
      after_vld = bus.out_valid;
      after_dat = bus.out_data;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (bus.out_can_accept_cmd !== 1'b1)
      $display("FAIL reset_can_accept: got %b want 1", bus.out_can_accept_cmd);
    if (bus.out_can_accept_cmd !== 1'b1) errors++;
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_valid: got %b want 0", bus.out_valid);
    end
    checks++;
    if (bus.out_data !== '0) begin
      errors++;
      $display("FAIL reset_data: got %h want 0", bus.out_data);
    end
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_directed(input string name, input logic [255:0] v, input logic [1:0] sz,
                               input logic sg, input logic [255:0] exp_dat, input int exp_lat);
    logic [255:0] got, after_dat;
    int lat;
    logic after_vld;
    run_cmd(v, sz, sg, got, lat, after_vld, after_dat);
    checks++;
    if (got !== exp_dat) begin
      errors++;
      $display("FAIL %s_data: got %h want %h", name, got, exp_dat);
    end
    checks++;
    if (lat != exp_lat) begin
      errors++;
      $display("FAIL %s_latency: got %0d want %0d", name, lat, exp_lat);
    end
    checks++;
    if (after_vld !== 1'b0) begin
      errors++;
      $display("FAIL %s_pulse: out_valid next cycle %b want 0", name, after_vld);
    end
  endtask

  task automatic test_u8();
    logic [255:0] v, e;
    for (int i = 0; i < 16; i++)  v[i*8 +: 8] = 8'h01;
    for (int i = 16; i < 32; i++) v[i*8 +: 8] = 8'hFF;
    for (int i = 0; i < 16; i++)  e[i*16 +: 16] = 16'h3F80;
    test_directed("u8", v, 2'd0, 1'b0, e, 50);
  endtask

  task automatic test_s16();
    logic [255:0] v, e;
    v = '0; v[15:0] = 16'hFFFF; v[31:16] = 16'h0002;
    e = '0; e[15:0] = 16'hBF80; e[31:16] = 16'h4000;
    test_directed("s16", v, 2'd1, 1'b1, e, 50);
  endtask

  task automatic test_u32();
    logic [255:0] v, e;
    e = '0;
    for (int i = 0; i < 8; i++) begin
      v[i*32 +: 32] = 32'd255;
      e[i*16 +: 16] = 16'h437F;
    end
    test_directed("u32", v, 2'd2, 1'b0, e, 26);
  endtask

  task automatic test_s64();
    logic [255:0] v, e;
    v = '0; v[63:0] = 64'hFFFF_FFFF_FFFF_FFFF; v[127:64] = 64'd1; v[255:192] = 64'd2;
    e = '0; e[15:0] = 16'hBF80; e[31:16] = 16'h3F80; e[63:48] = 16'h4000;
    test_directed("s64", v, 2'd3, 1'b1, e, 14);
  endtask

  task automatic test_random();
    logic [255:0] v, got, after_dat, exp_dat;
    logic [1:0] sz;
    logic sg, after_vld;
    int lat;
    for (int it = 0; it < 10; it++) begin
      v  = rand_vec();
      sz = 2'($urandom_range(0, 3));
      sg = 1'($urandom_range(0, 1));
      exp_dat = ref_vec(v, sz, sg);
      run_cmd(v, sz, sg, got, lat, after_vld, after_dat);
      checks++;
      if (got !== exp_dat) begin
        errors++;
        $display("FAIL rand%0d_data sz=%0d sg=%0d: got %h want %h", it, sz, sg, got, exp_dat);
      end
      checks++;
      if (lat != 3 * num_elems(sz) + 2) begin
        errors++;
        $display("FAIL rand%0d_latency: got %0d want %0d", it, lat, 3 * num_elems(sz) + 2);
      end
      checks++;
      if (after_vld !== 1'b0 || after_dat !== exp_dat) begin
        errors++;
        $display("FAIL rand%0d_hold: valid %b data %h want 0 / %h", it, after_vld, after_dat, exp_dat);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [255:0] v1, v2, exp1, exp2, d1, d2;
    int pulses, c1, c2;
    v1 = rand_vec();
    v2 = rand_vec();
    exp1 = ref_vec(v1, 2'd3, 1'b1);
    exp2 = ref_vec(v2, 2'd2, 1'b0);
    d1 = '0; d2 = '0; pulses = 0; c1 = -100; c2 = -100;
    bus.in_to_cast         = v1;
    bus.in_int_type_size   = IntTypSz64;
    bus.in_type_signedness = 1'b1;
    bus.in_start           = 1'b1;
    @(posedge clk); #1;
    // Keep start high but change every command field while busy.
    bus.in_to_cast         = rand_vec();
    bus.in_int_type_size   = IntTypSz8;
    bus.in_type_signedness = 1'b0;
    for (int c = 1; c <= 150; c++) begin
      @(posedge clk); #1;
      if (bus.out_valid === 1'b1) begin
        pulses++;
        if (pulses == 1) begin
          c1 = c;
          d1 = bus.out_data;
          bus.in_to_cast         = v2;
          bus.in_int_type_size   = IntTypSz32;
          bus.in_type_signedness = 1'b0;
        end else if (pulses == 2) begin
          c2 = c;
          d2 = bus.out_data;
        end
      end else if (pulses == 1 && c == c1 + 1) begin
        bus.in_start = 1'b0;
        checks++;
        if (bus.out_can_accept_cmd !== 1'b0) begin
          errors++;
          $display("FAIL b2b_accept: can_accept %b want 0 after second start", bus.out_can_accept_cmd);
        end
      end
    end
    bus.in_start = 1'b0;
    checks++;
    if (pulses != 2) begin
      errors++;
      $display("FAIL b2b_pulses: got %0d want 2", pulses);
    end
    checks++;
    if (d1 !== exp1) begin
      errors++;
      $display("FAIL b2b_data1: got %h want %h", d1, exp1);
    end
    checks++;
    if (d2 !== exp2) begin
      errors++;
      $display("FAIL b2b_data2: got %h want %h", d2, exp2);
    end
    checks++;
    if (c1 + 1 != 14) begin
      errors++;
      $display("FAIL b2b_latency1: got %0d want 14", c1 + 1);
    end
    checks++;
    if (c2 - c1 != 26) begin
      errors++;
      $display("FAIL b2b_latency2: got %0d want 26", c2 - c1);
    end
  endtask

  task automatic test_reset_mid();
    logic [255:0] v, got, after_dat, exp_dat;
    logic after_vld;
    int lat, stray;
    bus.in_to_cast         = rand_vec();
    bus.in_int_type_size   = IntTypSz16;
    bus.in_type_signedness = 1'b1;
    bus.in_start           = 1'b1;
    @(posedge clk); #1;
    bus.in_start = 1'b0;
    // Lane 5 is issued at cycle 15 and waited on in cycles 16 and 17.
    repeat (16) @(posedge clk);
    #1;
    checks++;
    if (bus.out_can_accept_cmd !== 1'b0 || bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL midrst_busy: can_accept %b valid %b want 0/0", bus.out_can_accept_cmd, bus.out_valid);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++;
    if (bus.out_can_accept_cmd !== 1'b1) begin
      errors++;
      $display("FAIL midrst_can_accept: got %b want 1", bus.out_can_accept_cmd);
    end
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL midrst_valid: got %b want 0", bus.out_valid);
    end
    checks++;
    if (bus.out_data !== '0) begin
      errors++;
      $display("FAIL midrst_data: got %h want 0", bus.out_data);
    end
    stray = 0;
    for (int c = 0; c < 60; c++) begin
      @(posedge clk); #1;
      if (bus.out_valid === 1'b1) stray++;
    end
    checks++;
    if (stray != 0) begin
      errors++;
      $display("FAIL midrst_stray_valid: got %0d pulses want 0", stray);
    end
    v = rand_vec();
    exp_dat = ref_vec(v, 2'd3, 1'b1);
    run_cmd(v, 2'd3, 1'b1, got, lat, after_vld, after_dat);
    checks++;
    if (got !== exp_dat) begin
      errors++;
      $display("FAIL midrst_fresh_data: got %h want %h", got, exp_dat);
    end
    checks++;
    if (lat != 14) begin
      errors++;
      $display("FAIL midrst_fresh_latency: got %0d want 14", lat);
    end
  endtask

  initial begin
    rst                    = 1'b1;
    bus.in_start           = 1'b0;
    bus.in_to_cast         = '0;
    bus.in_int_type_size   = IntTypSz8;
    bus.in_type_signedness = 1'b0;
    test_reset();
    test_u8();
    test_s16();
    test_u32();
    test_s64();
    test_random();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
